avaliador_nota_tempo: RTL and testbench
=======================================

Name: avaliador_nota_tempo

Overview:
Parametrised per-note evaluation engine for the didactic piano; the next generation of the single-key compare/tempo-check path in the top-level datapath. It supports N keys and chords (multi-key masks), and measures press duration in metronome ticks. It checks note and duration against an expected value within a programmable tolerance, detects timeout, and keeps a saturating error count. The control FSM starts it once per note with a start pulse and gets a one-cycle done pulse back.

Parameters:
NUM_TECLAS, 13, number of keys; width of key and expected-note masks
TEMPO_W, 4, width of duration counter and expected duration
TOL, 1, accepted absolute deviation in ticks between measured and expected duration
TIMEOUT_TICKS, 10, ticks allowed in ESPERA before timeout (>=1, < 2^TEMPO_W)
ERRO_W, 3, width of error counter

Ports:
clock  in  1  system clock, all state rising-edge
reset  in  1  asynchronous, active-high; forces all state to reset values
inicia  in  1  start pulse; accepted only in OCIOSO
tick  in  1  one-clock metronome half-beat pulse
botoes  in  NUM_TECLAS  raw (already debounced) key levels
esperado_nota  in  NUM_TECLAS  expected key mask (one-hot, or several bits for a chord)
esperado_tempo  in  TEMPO_W  expected duration in ticks
zera_erros  in  1  synchronous clear of erros
ocupado  out  1  high in every state except OCIOSO
pronto  out  1  one-cycle pulse in RESULTADO
nota_ok  out  1  registered; captured mask == expected mask
tempo_ok  out  1  registered; |medido - esperado| <= TOL
timeout  out  1  registered; no press within TIMEOUT_TICKS
medido_tempo  out  TEMPO_W  registered measured duration
erros  out  ERRO_W  saturating error count

Behaviour:
- Reset values: state OCIOSO; all outputs 0; internal mask, counters and expected registers 0.
- States: OCIOSO, ESPERA, MEDE, RESULTADO (2-bit encoding).
- OCIOSO: on inicia, register esperado_nota/esperado_tempo, clear tick counter, clear captured mask, clear nota_ok/tempo_ok/timeout/medido_tempo, then go to ESPERA. Expected inputs are ignored after that cycle.
- ESPERA: tick counter increments on each tick.
  - Press = OR(botoes) is 1 and was 0 the previous clock (edge on internal 1-cycle delayed OR).
  - On a press: mask <= botoes, duration <= 0, go to MEDE.
  - If the tick counter reaches TIMEOUT_TICKS with no press: timeout <= 1, go to RESULTADO.
  - A press and the terminal tick in the same cycle: press wins.
  - Keys already held at inicia do not count until they are released and pressed again.
- MEDE: mask <= mask | botoes every cycle (chord accumulation). Duration increments on tick and saturates at 2^TEMPO_W-1. When OR(botoes)==0, go to RESULTADO. A tick in the release cycle is still counted.
- RESULTADO (exactly 1 cycle):
  - pronto=1; medido_tempo <= duration.
  - nota_ok <= (mask == esperado) and !timeout.
  - tempo_ok <= abs difference, computed in TEMPO_W+1 bits unsigned, <= TOL, and !timeout.
  - erros increments, saturating at 2^ERRO_W-1, if timeout or !(nota_ok & tempo_ok).
  - Next state: OCIOSO.
- Result outputs are valid from the cycle after pronto and hold until the next accepted inicia.
- inicia outside OCIOSO is ignored.
- zera_erros has priority over a same-cycle increment and acts in any state.
- Reset mid-operation aborts immediately to OCIOSO with no pronto. erros is cleared.
- Latency: inicia to ocupado is 1 clock. Release to pronto is 1 clock.

Decomposition:
- Shared package (pkg_fpgaudio): state encoding constants OCIOSO/ESPERA/MEDE/RESULTADO, and the default NUM_TECLAS=13.
- One natural sub-module, contador_sat, instantiated twice (duration counter and erros):
  - Parameter W.
  - Ports: clock, reset, zera, conta, Q.
  - Saturates at all-ones.
- Tick counter, press edge detector and FSM stay inline.

Test Plan:
- Correct note: esperado_nota=0x0004, esperado_tempo=4; inicia; press bit2, 4 ticks, release -> pronto 1 cycle after release, nota_ok=1, tempo_ok=1, medido_tempo=4, erros=0.
- Tolerance edge (TOL=1): expected 4, hold 5 ticks -> tempo_ok=1. Hold 6 ticks -> tempo_ok=0, erros=1. Hold 3 -> tempo_ok=1. Hold 2 -> tempo_ok=0.
- Chord: esperado_nota=0x0011; press bit0, then bit4 two cycles later, release both -> nota_ok=1. Repeat with only bit0 -> nota_ok=0, erros increments.
- Timeout: inicia, no keys, 10 ticks -> timeout=1, pronto, nota_ok=0, tempo_ok=0, erros+1. Key held from before inicia also yields timeout.
- Saturation: ERRO_W=3, force 9 consecutive errors -> erros stays 7. Duration held 20 ticks with TEMPO_W=4 -> medido_tempo=15. zera_erros together with an error -> erros=0.
- Reset in MEDE: assert reset mid-press -> ocupado=0, pronto never pulses, all outputs 0. inicia during MEDE has no effect.

Source files
------------

// File: rtl/avaliador_nota_tempo_pkg.sv
// Shared definitions for the FPGAudio note path: control state encoding and default key count.
package pkg_fpgaudio;

  localparam int NUM_TECLAS_PADRAO = 13;

  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    ESPERA    = 2'b01,
    MEDE      = 2'b10,
    RESULTADO = 2'b11
  } estado_t;

endpackage

// File: rtl/avaliador_nota_tempo_if.sv
// Bus between the control FSM (master) and the note/tempo evaluator (slave).
interface avaliador_nota_tempo_if
  import pkg_fpgaudio::*;
#(
  parameter int NUM_TECLAS = NUM_TECLAS_PADRAO,
  parameter int TEMPO_W    = 4,
  parameter int ERRO_W     = 3
) ();

  logic                  inicia;
  logic                  tick;
  logic [NUM_TECLAS-1:0] botoes;
  logic [NUM_TECLAS-1:0] esperado_nota;
  logic [TEMPO_W-1:0]    esperado_tempo;
  logic                  zera_erros;
  logic                  ocupado;
  logic                  pronto;
  logic                  nota_ok;
  logic                  tempo_ok;
  logic                  timeout;
  logic [TEMPO_W-1:0]    medido_tempo;
  logic [ERRO_W-1:0]     erros;

  modport master (
    output inicia, tick, botoes, esperado_nota, esperado_tempo, zera_erros,
    input  ocupado, pronto, nota_ok, tempo_ok, timeout, medido_tempo, erros
  );

  modport slave (
    input  inicia, tick, botoes, esperado_nota, esperado_tempo, zera_erros,
    output ocupado, pronto, nota_ok, tempo_ok, timeout, medido_tempo, erros
  );

endinterface

// File: rtl/avaliador_nota_tempo_contador_sat.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over counting.
module contador_sat #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] Q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  Q <= '0;
    else if (zera)              Q <= '0;
    else if (conta && Q != '1)  Q <= Q + W'(1);
  end

endmodule

// File: rtl/avaliador_nota_tempo.sv
// Per-note evaluator: waits for a key press, measures hold time in ticks, grades note and tempo.
module avaliador_nota_tempo
  import pkg_fpgaudio::*;
#(
  parameter int NUM_TECLAS    = NUM_TECLAS_PADRAO,
  parameter int TEMPO_W       = 4,
  parameter int TOL           = 1,
  parameter int TIMEOUT_TICKS = 10,
  parameter int ERRO_W        = 3
) (
  input logic                   clock,
  input logic                   reset,
  avaliador_nota_tempo_if.slave bus
);

  localparam logic [TEMPO_W-1:0] TICK_FINAL = TEMPO_W'(TIMEOUT_TICKS - 1);
  localparam logic [TEMPO_W:0]   TOL_EXT    = (TEMPO_W + 1)'(TOL);

  estado_t               estado, prox_estado;
  logic [NUM_TECLAS-1:0] mascara, esp_nota;
  logic [TEMPO_W-1:0]    esp_tempo, cont_tick, duracao, medido_r;
  logic [TEMPO_W:0]      dif, dif_abs;
  logic [ERRO_W-1:0]     erros_q;
  logic                  or_botoes, or_d, press, fim_espera, aceita;
  logic                  zera_dur, conta_dur, conta_erro;
  logic                  nota_ok_c, tempo_ok_c, erro_c;
  logic                  nota_ok_r, tempo_ok_r, timeout_r;

  // Press is the rising edge of "any key down", so keys held at start never count.
  assign or_botoes  = |bus.botoes;
  assign press      = or_botoes & ~or_d;
  assign fim_espera = bus.tick && (cont_tick == TICK_FINAL);
  assign aceita     = (estado == OCIOSO) && bus.inicia;

  // NOTE: sequential state uses <= so every flop samples pre-edge values; = would race.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= prox_estado;
  end

  always_comb begin
    // NOTE: default first so no path leaves prox_estado unassigned (no latch).
    prox_estado = estado;
    case (estado)
      OCIOSO:    if (bus.inicia) prox_estado = ESPERA;
      ESPERA:    if (press) prox_estado = MEDE;
                 else if (fim_espera) prox_estado = RESULTADO;
      MEDE:      if (!or_botoes) prox_estado = RESULTADO;
      RESULTADO: prox_estado = OCIOSO;
      default:   prox_estado = OCIOSO;
    endcase
  end

  // Grading is evaluated from the held registers during the single RESULTADO cycle.
  always_comb begin
    dif        = {1'b0, duracao} - {1'b0, esp_tempo};
    dif_abs    = dif[TEMPO_W] ? -dif : dif;
    nota_ok_c  = (mascara == esp_nota) && !timeout_r;
    tempo_ok_c = (dif_abs <= TOL_EXT) && !timeout_r;
    erro_c     = timeout_r || !(nota_ok_c && tempo_ok_c);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      or_d       <= 1'b0;
      mascara    <= '0;
      esp_nota   <= '0;
      esp_tempo  <= '0;
      cont_tick  <= '0;
      medido_r   <= '0;
      nota_ok_r  <= 1'b0;
      tempo_ok_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      or_d <= or_botoes;
      case (estado)
        OCIOSO: if (bus.inicia) begin
          esp_nota   <= bus.esperado_nota;
          esp_tempo  <= bus.esperado_tempo;
          cont_tick  <= '0;
          mascara    <= '0;
          medido_r   <= '0;
          nota_ok_r  <= 1'b0;
          tempo_ok_r <= 1'b0;
          timeout_r  <= 1'b0;
        end
        ESPERA: begin
          if (bus.tick) cont_tick <= cont_tick + TEMPO_W'(1);
          if (press)           mascara   <= bus.botoes;
          else if (fim_espera) timeout_r <= 1'b1;
        end
        MEDE:      mascara <= mascara | bus.botoes;
        RESULTADO: begin
          medido_r   <= duracao;
          nota_ok_r  <= nota_ok_c;
          tempo_ok_r <= tempo_ok_c;
        end
        default: ;
      endcase
    end
  end

  // Duration also clears on accepted start so a timed-out note reports zero.
  assign zera_dur   = aceita || ((estado == ESPERA) && press);
  assign conta_dur  = (estado == MEDE) && bus.tick;
  assign conta_erro = (estado == RESULTADO) && erro_c;

  contador_sat #(.W(TEMPO_W)) u_duracao (
    .clock (clock),
    .reset (reset),
    .zera  (zera_dur),
    .conta (conta_dur),
    .Q     (duracao)
  );

  contador_sat #(.W(ERRO_W)) u_erros (
    .clock (clock),
    .reset (reset),
    .zera  (bus.zera_erros),
    .conta (conta_erro),
    .Q     (erros_q)
  );

  assign bus.ocupado      = (estado != OCIOSO);
  assign bus.pronto       = (estado == RESULTADO);
  assign bus.nota_ok      = nota_ok_r;
  assign bus.tempo_ok     = tempo_ok_r;
  assign bus.timeout      = timeout_r;
  assign bus.medido_tempo = medido_r;
  assign bus.erros        = erros_q;

endmodule

// File: tb/tb_avaliador_nota_tempo.sv
// Self-checking bench for avaliador_nota_tempo against a per-note behavioural model.
module tb_avaliador_nota_tempo;

  localparam int NT   = 13;
  localparam int TW   = 4;
  localparam int TOLR = 1;
  localparam int TO   = 10;
  localparam int EW   = 3;
  localparam int DMAX = (1 << TW) - 1;
  localparam int EMAX = (1 << EW) - 1;

  logic clock = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;
  int   erros_m = 0;

  always #5 clock = ~clock;

  avaliador_nota_tempo_if #(.NUM_TECLAS(NT), .TEMPO_W(TW), .ERRO_W(EW)) bus ();

  avaliador_nota_tempo #(
    .NUM_TECLAS(NT), .TEMPO_W(TW), .TOL(TOLR), .TIMEOUT_TICKS(TO), .ERRO_W(EW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // One note: start, idle ticks, press k1 (k2 joins after k2_delay cycles), hold, release, grade.
  task automatic note(input string nome, input logic [NT-1:0] esp_n, input int esp_t,
                      input logic [NT-1:0] k1, input logic [NT-1:0] k2, input int k2_delay,
                      input int hold, input int idle, input bit tick_rel,
                      input bit zera_res, input bit inicia_meio);
    logic [NT-1:0] cap;
    int dur, d, c;
    bit nok, tok;
    @(negedge clock);
    bus.esperado_nota = esp_n; bus.esperado_tempo = TW'(esp_t); bus.inicia = 1'b1;
    @(negedge clock);
    bus.inicia = 1'b0; bus.esperado_nota = NT'($urandom); bus.esperado_tempo = TW'($urandom);
    n_total++; if (bus.ocupado !== 1'b1) $display("FAIL %s_ocupado: got %b want 1", nome, bus.ocupado); else n_pass++;
    for (int i = 0; i < idle; i++) begin
      bus.tick = 1'b1; @(negedge clock); bus.tick = 1'b0; @(negedge clock);
    end
    bus.botoes = k1; cap = k1; c = 0;
    @(negedge clock);
    for (int i = 0; i < 2 * hold; i++) begin
      bus.tick   = (i % 2 == 0);
      bus.inicia = inicia_meio && (i == 0);
      if (k2 != '0 && c == k2_delay) begin bus.botoes = bus.botoes | k2; cap = cap | k2; end
      @(negedge clock); c++;
    end
    bus.inicia = 1'b0; bus.tick = tick_rel; bus.botoes = '0;
    n_total++; if (bus.pronto !== 1'b0) $display("FAIL %s_pronto_cedo: got %b want 0", nome, bus.pronto); else n_pass++;
    @(negedge clock);
    bus.tick = 1'b0;
    n_total++; if (bus.pronto !== 1'b1) $display("FAIL %s_pronto: got %b want 1", nome, bus.pronto); else n_pass++;
    bus.zera_erros = zera_res;
    @(negedge clock);
    bus.zera_erros = 1'b0;
    dur = hold + (tick_rel ? 1 : 0);
    if (dur > DMAX) dur = DMAX;
    d = dur - esp_t;
    if (d < 0) d = -d;
    nok = (cap == esp_n);
    tok = (d <= TOLR);
    if (zera_res) erros_m = 0;
    else if (!(nok && tok) && erros_m < EMAX) erros_m++;
    n_total++; if (bus.pronto !== 1'b0) $display("FAIL %s_pronto_largo: got %b want 0", nome, bus.pronto); else n_pass++;
    n_total++; if (bus.ocupado !== 1'b0) $display("FAIL %s_livre: got %b want 0", nome, bus.ocupado); else n_pass++;
    n_total++; if (bus.nota_ok !== nok) $display("FAIL %s_nota_ok: got %b want %b", nome, bus.nota_ok, nok); else n_pass++;
    n_total++; if (bus.tempo_ok !== tok) $display("FAIL %s_tempo_ok: got %b want %b", nome, bus.tempo_ok, tok); else n_pass++;
    n_total++; if (bus.timeout !== 1'b0) $display("FAIL %s_timeout: got %b want 0", nome, bus.timeout); else n_pass++;
    n_total++; if (bus.medido_tempo !== TW'(dur)) $display("FAIL %s_medido: got %0d want %0d", nome, bus.medido_tempo, dur); else n_pass++;
    n_total++; if (bus.erros !== EW'(erros_m)) $display("FAIL %s_erros: got %0d want %0d", nome, bus.erros, erros_m); else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_total++; if (bus.ocupado !== 1'b0) $display("FAIL reset_ocupado: got %b want 0", bus.ocupado); else n_pass++;
    n_total++; if (bus.pronto !== 1'b0) $display("FAIL reset_pronto: got %b want 0", bus.pronto); else n_pass++;
    n_total++; if ({bus.nota_ok, bus.tempo_ok, bus.timeout} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {bus.nota_ok, bus.tempo_ok, bus.timeout}); else n_pass++;
    n_total++; if (bus.medido_tempo !== '0) $display("FAIL reset_medido: got %0d want 0", bus.medido_tempo); else n_pass++;
    n_total++; if (bus.erros !== '0) $display("FAIL reset_erros: got %0d want 0", bus.erros); else n_pass++;
    reset = 1'b0;
    erros_m = 0;
    @(negedge clock);
    n_total++; if (bus.ocupado !== 1'b0) $display("FAIL reset_pos_ocupado: got %b want 0", bus.ocupado); else n_pass++;
  endtask

  task automatic test_nota_correta;
    note("correta", 13'h0004, 4, 13'h0004, '0, 0, 4, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_tolerancia;
    note("tol_5", 13'h0004, 4, 13'h0004, '0, 0, 5, 1, 1'b0, 1'b0, 1'b0);
    note("tol_6", 13'h0004, 4, 13'h0004, '0, 0, 6, 1, 1'b0, 1'b0, 1'b0);
    note("tol_3", 13'h0004, 4, 13'h0004, '0, 0, 3, 1, 1'b0, 1'b0, 1'b0);
    note("tol_2", 13'h0004, 4, 13'h0004, '0, 0, 2, 1, 1'b0, 1'b0, 1'b0);
    note("tick_soltura", 13'h0004, 4, 13'h0004, '0, 0, 3, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_acorde;
    note("acorde", 13'h0011, 3, 13'h0001, 13'h0010, 1, 3, 0, 1'b0, 1'b0, 1'b0);
    note("acorde_parcial", 13'h0011, 3, 13'h0001, '0, 0, 3, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_inicia_ignorado;
    note("inicia_mede", 13'h0100, 2, 13'h0100, '0, 0, 2, 1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_timeout(input bit held);
    logic [NT-1:0] k;
    k = held ? (NT'(1) << $urandom_range(0, NT - 1)) : '0;
    @(negedge clock);
    bus.botoes = k;
    @(negedge clock);
    bus.esperado_nota = k; bus.esperado_tempo = '0; bus.inicia = 1'b1;
    @(negedge clock);
    bus.inicia = 1'b0;
    for (int i = 0; i < TO; i++) begin
      bus.tick = 1'b1; @(negedge clock); bus.tick = 1'b0;
      if (i < TO - 1) begin
        n_total++; if (bus.pronto !== 1'b0) $display("FAIL timeout_cedo: got %b want 0 at tick %0d", bus.pronto, i); else n_pass++;
        @(negedge clock);
      end
    end
    n_total++; if (bus.pronto !== 1'b1) $display("FAIL timeout_pronto: got %b want 1", bus.pronto); else n_pass++;
    @(negedge clock);
    bus.botoes = '0;
    if (erros_m < EMAX) erros_m++;
    n_total++; if (bus.timeout !== 1'b1) $display("FAIL timeout_flag: got %b want 1", bus.timeout); else n_pass++;
    n_total++; if ({bus.nota_ok, bus.tempo_ok} !== 2'b00) $display("FAIL timeout_ok: got %b want 00", {bus.nota_ok, bus.tempo_ok}); else n_pass++;
    n_total++; if (bus.erros !== EW'(erros_m)) $display("FAIL timeout_erros: got %0d want %0d", bus.erros, erros_m); else n_pass++;
  endtask

  task automatic test_saturacao;
    @(negedge clock);
    bus.zera_erros = 1'b1;
    @(negedge clock);
    bus.zera_erros = 1'b0;
    erros_m = 0;
    n_total++; if (bus.erros !== '0) $display("FAIL sat_zera: got %0d want 0", bus.erros); else n_pass++;
    for (int i = 0; i < 9; i++) note("sat_erro", 13'h0001, 1, 13'h0002, '0, 0, 1, 0, 1'b0, 1'b0, 1'b0);
    note("sat_duracao", 13'h0040, 15, 13'h0040, '0, 0, 20, 0, 1'b0, 1'b0, 1'b0);
    note("zera_com_erro", 13'h0001, 1, 13'h0002, '0, 0, 1, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_aleatorio;
    logic [NT-1:0] esp_n, k1;
    for (int n = 0; n < 20; n++) begin
      esp_n = NT'(1) << $urandom_range(0, NT - 1);
      if ($urandom_range(0, 3) == 0) esp_n = esp_n | (NT'(1) << $urandom_range(0, NT - 1));
      k1 = ($urandom_range(0, 1) == 1) ? esp_n : (NT'(1) << $urandom_range(0, NT - 1));
      note("aleatorio", esp_n, $urandom_range(0, DMAX), k1, '0, 0, $urandom_range(0, 18),
           $urandom_range(0, TO - 2), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mede;
    int pulsos;
    note("pre_reset", 13'h0008, 2, 13'h0008, '0, 0, 7, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    bus.esperado_nota = 13'h0004; bus.esperado_tempo = 4'd4; bus.inicia = 1'b1;
    @(negedge clock);
    bus.inicia = 1'b0; bus.botoes = 13'h0004;
    repeat (2) begin
      @(negedge clock); bus.tick = 1'b1; @(negedge clock); bus.tick = 1'b0;
    end
    reset = 1'b1;
    #1;
    erros_m = 0;
    n_total++; if (bus.ocupado !== 1'b0) $display("FAIL rst_mede_ocupado: got %b want 0", bus.ocupado); else n_pass++;
    n_total++; if ({bus.nota_ok, bus.tempo_ok, bus.timeout} !== 3'b000) $display("FAIL rst_mede_flags: got %b want 000", {bus.nota_ok, bus.tempo_ok, bus.timeout}); else n_pass++;
    n_total++; if (bus.medido_tempo !== '0) $display("FAIL rst_mede_medido: got %0d want 0", bus.medido_tempo); else n_pass++;
    n_total++; if (bus.erros !== '0) $display("FAIL rst_mede_erros: got %0d want 0", bus.erros); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    bus.botoes = '0;
    pulsos = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus.pronto === 1'b1 || bus.ocupado === 1'b1) pulsos++;
    end
    n_total++; if (pulsos != 0) $display("FAIL rst_mede_pronto: got %0d busy/pronto cycles want 0", pulsos); else n_pass++;
  endtask

  initial begin
    reset              = 1'b1;
    bus.inicia         = 1'b0;
    bus.tick           = 1'b0;
    bus.botoes         = '0;
    bus.esperado_nota  = '0;
    bus.esperado_tempo = '0;
    bus.zera_erros     = 1'b0;
    test_reset();
    test_nota_correta();
    test_tolerancia();
    test_acorde();
    test_inicia_ignorado();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_saturacao();
    test_aleatorio();
    test_reset_mede();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
